pgm_sched: RTL

- Sequencing controller for the packet generator's stored-packet RAM (144-bit x 128-line dual-port RAM, read port B).
- Once a template packet sits in RAM lines 0..cfg_last_addr, replays it cfg_pkt_num times (or continuously) on the 134-bit data/valid stream toward the output engine.
- Inserts a configurable inter-packet gap and honours downstream almost-full (alf) at packet boundaries.
- Reports start/finish pulses and a sent-packet count back to the header-processing control logic.

---
 rtl/pgm_sched.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pgm_sched.sv
// Replays a stored packet template from RAM lines 0..last_addr onto the
// data/valid stream, with inter-packet gap, alf back-pressure and run control.
module pgm_sched #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned GAP_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic [CNT_W-1:0]  cfg_pkt_num,
  input  logic [GAP_W-1:0]  cfg_gap,
  input  logic [ADDR_W-1:0] cfg_last_addr,
  input  logic              in_alf,
  output logic              rd2ram_rd,
  output logic [ADDR_W-1:0] rd2ram_addr,
  input  logic [143:0]      ram2rd_rdata,
  output logic [133:0]      out_data,
  output logic              out_data_wr,
  output logic              out_valid,
  output logic              out_valid_wr,
  output logic              sent_start_flag,
  output logic              sent_finish_flag,
  output logic [CNT_W-1:0]  sent_cnt,
  output logic              busy
);

  localparam int unsigned DATA_W = 134;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_EOP,
    S_GAP
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   pkt_num_q;
  logic [GAP_W-1:0]   gap_q;
  logic [ADDR_W-1:0]  last_q;
  logic [GAP_W-1:0]   gap_cnt;
  logic               stop_pending;
  logic               done_c;
  logic               ram_unused;

  // The RAM carries 10 spare bits above the 134-bit stream word.
  assign ram_unused = ^ram2rd_rdata[143:DATA_W];

  // Run ends on the packet that reaches the target count, or on any stop seen so far.
  assign done_c = ((pkt_num_q != '0) && ((sent_cnt + CNT_W'(1)) == pkt_num_q))
                  || stop_pending || cfg_stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      pkt_num_q        <= '0;
      gap_q            <= '0;
      last_q           <= '0;
      gap_cnt          <= '0;
      stop_pending     <= 1'b0;
      rd2ram_rd        <= 1'b0;
      rd2ram_addr      <= '0;
      out_data         <= '0;
      out_data_wr      <= 1'b0;
      out_valid        <= 1'b0;
      out_valid_wr     <= 1'b0;
      sent_start_flag  <= 1'b0;
      sent_finish_flag <= 1'b0;
      sent_cnt         <= '0;
      busy             <= 1'b0;
    end else begin
      rd2ram_rd        <= 1'b0;
      out_data_wr      <= 1'b0;
      out_valid        <= 1'b0;
      out_valid_wr     <= 1'b0;
      sent_start_flag  <= 1'b0;
      sent_finish_flag <= 1'b0;

      if (cfg_stop && (state != S_IDLE)) stop_pending <= 1'b1;

      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            pkt_num_q       <= cfg_pkt_num;
            gap_q           <= cfg_gap;
            last_q          <= cfg_last_addr;
            sent_cnt        <= '0;
            stop_pending    <= 1'b0;
            sent_start_flag <= 1'b1;
            busy            <= 1'b1;
            if (!in_alf) begin
              state       <= S_READ;
              rd2ram_rd   <= 1'b1;
              rd2ram_addr <= '0;
            end else begin
              state <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (!in_alf) begin
            state       <= S_READ;
            rd2ram_rd   <= 1'b1;
            rd2ram_addr <= '0;
          end
        end

        // Word for the address issued this cycle is captured at the closing edge.
        S_READ: begin
          out_data_wr <= 1'b1;
          out_data    <= ram2rd_rdata[DATA_W-1:0];
          if (rd2ram_addr == last_q) begin
            state        <= S_EOP;
            out_valid    <= 1'b1;
            out_valid_wr <= 1'b1;
          end else begin
            rd2ram_rd   <= 1'b1;
            rd2ram_addr <= rd2ram_addr + ADDR_W'(1);
          end
        end

        S_EOP: begin
          sent_cnt <= sent_cnt + CNT_W'(1);
          if (done_c) begin
            state            <= S_IDLE;
            sent_finish_flag <= 1'b1;
            busy             <= 1'b0;
            stop_pending     <= 1'b0;
          end else if (gap_q != '0) begin
            state   <= S_GAP;
            gap_cnt <= gap_q;
          end else if (!in_alf) begin
            state       <= S_READ;
            rd2ram_rd   <= 1'b1;
            rd2ram_addr <= '0;
          end else begin
            state <= S_WAIT;
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_W'(1)) begin
            if (!in_alf) begin
              state       <= S_READ;
              rd2ram_rd   <= 1'b1;
              rd2ram_addr <= '0;
            end else begin
              state <= S_WAIT;
            end
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
